// File: rtl/audio_pkg.sv
// Shared constants and types for the audio PWM output stage.
package audio_pkg;

  localparam int AUDIO_DATA_W = 8;
  localparam int AUDIO_FIFO_DEPTH = 4;
  localparam logic [7:0] AUDIO_RESET_DUTY = 8'h80;

  typedef struct packed {
    logic full;
    logic empty;
  } fifo_flags_t;

  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/audio_pwm_out_if.sv
// Sample stream handshake from the mixer into the PWM output stage.
interface audio_pwm_out_if
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/audio_pwm_out_sample_fifo.sv
// Synchronous sample buffer; pointers carry one extra wrap bit to tell full from empty.
module sample_fifo
  import audio_pkg::*;
#(
  parameter int WIDTH = AUDIO_DATA_W,
  parameter int DEPTH = AUDIO_FIFO_DEPTH,
  localparam int PTR_W = level_w(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W-1:0] level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                 (wr_ptr[PTR_W-2:0] == rd_ptr[PTR_W-2:0]);
  assign level = wr_ptr - rd_ptr;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[PTR_W-2:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: the pointers alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-2:0]] <= wdata;
  end

endmodule

// File: rtl/audio_pwm_out.sv
// Audio output stage: buffers PCM samples and renders one sample per PWM period.
module audio_pwm_out
  import audio_pkg::*;
#(
  parameter int DATA_W = AUDIO_DATA_W,
  parameter int FIFO_DEPTH = AUDIO_FIFO_DEPTH,
  parameter logic [DATA_W-1:0] RESET_DUTY = AUDIO_RESET_DUTY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  audio_pwm_out_if.slave                s,
  input  logic                          clr_underflow,
  output logic                          pwm_out,
  output logic                          sample_tick,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam logic [DATA_W-1:0] CNT_MAX = '1;

  logic [DATA_W-1:0] cnt;
  logic [DATA_W-1:0] cnt_next;
  logic [DATA_W-1:0] duty;
  logic [DATA_W-1:0] duty_next;
  logic [DATA_W-1:0] head;
  logic              boundary;
  logic              pop;
  logic              push;
  fifo_flags_t       flags;

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (s.data),
    .pop   (pop),
    .rdata (head),
    .full  (flags.full),
    .empty (flags.empty),
    .level (fifo_level)
  );

  // Ready depends only on registered FIFO state, so a pop in the same cycle
  // never opens a slot for a full buffer.
  assign s.ready = !flags.full;
  assign push    = s.valid && !flags.full;

  assign boundary  = enable && (cnt == CNT_MAX);
  assign pop       = boundary && !flags.empty;
  assign cnt_next  = enable ? cnt + 1'b1 : '0;
  assign duty_next = pop ? head : duty;

  // Comparing against next-state values lets a new duty start exactly on
  // the first cycle of the new period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      duty        <= RESET_DUTY;
      pwm_out     <= 1'b0;
      sample_tick <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      cnt         <= cnt_next;
      duty        <= duty_next;
      pwm_out     <= enable && (cnt_next < duty_next);
      sample_tick <= boundary;
      if (boundary && flags.empty) underflow <= 1'b1;
      else if (clr_underflow)      underflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_pwm_out.sv
// Self-checking bench for audio_pwm_out: queue-based reference model plus directed scenarios.
module tb_audio_pwm_out;
  import audio_pkg::*;

  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int PERIOD = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       clr_underflow;
  logic       pwm_out;
  logic       sample_tick;
  logic       underflow;
  logic [2:0] fifo_level;

  audio_pwm_out_if #(.DATA_W(DW)) s_if ();

  audio_pwm_out #(
    .DATA_W     (DW),
    .FIFO_DEPTH (DEPTH),
    .RESET_DUTY (8'h80)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .s             (s_if),
    .clr_underflow (clr_underflow),
    .pwm_out       (pwm_out),
    .sample_tick   (sample_tick),
    .underflow     (underflow),
    .fifo_level    (fifo_level)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: position within the period, current duty, and a queue of buffered samples.
  int m_pos;
  int m_duty;
  int m_q[$];
  bit m_pwm;
  bit m_tick;
  bit m_uf;

  always @(posedge clk or posedge rst) begin : model
    bit accept;
    bit bnd;
    bit was_empty;
    if (rst) begin
      m_pos = 0;
      m_duty = 128;
      m_q.delete();
      m_pwm = 0;
      m_tick = 0;
      m_uf = 0;
    end else begin
      accept    = (s_if.valid === 1'b1) && (m_q.size() < DEPTH);
      bnd       = (enable === 1'b1) && (m_pos == PERIOD - 1);
      was_empty = (m_q.size() == 0);
      m_tick = bnd;
      if (bnd && !was_empty) m_duty = m_q.pop_front();
      if (bnd && was_empty) m_uf = 1;
      else if (clr_underflow === 1'b1) m_uf = 0;
      if (accept) m_q.push_back(int'(s_if.data));
      m_pos = (enable === 1'b1) ? (m_pos + 1) % PERIOD : 0;
      m_pwm = (enable === 1'b1) && (m_pos < m_duty);
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("pwm_out", 32'(pwm_out), 32'(m_pwm));
      check("sample_tick", 32'(sample_tick), 32'(m_tick));
      check("underflow", 32'(underflow), 32'(m_uf));
      check("fifo_level", 32'(fifo_level), 32'(m_q.size()));
      check("s_ready", 32'(s_if.ready), 32'(m_q.size() < DEPTH));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d);
    int b = 0;
    s_if.valid = 1'b1;
    s_if.data  = d;
    while (s_if.ready !== 1'b1 && b < 1000) begin
      @(negedge clk);
      b++;
    end
    if (b >= 1000) check("push_timeout", 32'(b), 32'd0);
    @(negedge clk);
    s_if.valid = 1'b0;
  endtask

  task automatic wait_tick(output int waited);
    waited = 0;
    while (sample_tick !== 1'b1 && waited < 2 * PERIOD + 4) begin
      @(negedge clk);
      waited++;
    end
    if (sample_tick !== 1'b1) check("tick_timeout", 32'(sample_tick), 32'd1);
  endtask

  // Counts high cycles over one full period starting at the tick cycle.
  task automatic measure(output int hi, output int waited);
    wait_tick(waited);
    hi = 0;
    for (int i = 0; i < PERIOD; i++) begin
      hi += int'(pwm_out);
      @(negedge clk);
    end
  endtask

  initial begin
    int hi, w;
    logic [7:0] d[5];
    logic [7:0] x, a, b, c;
    int rate;

    rst = 1'b0;
    enable = 1'b0;
    clr_underflow = 1'b0;
    s_if.valid = 1'b0;
    s_if.data = '0;
    #1 rst = 1'b1;
    cyc(2);
    check("rst_pwm", 32'(pwm_out), 32'd0);
    check("rst_ready", 32'(s_if.ready), 32'd1);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_uf", 32'(underflow), 32'd0);
    check("rst_tick", 32'(sample_tick), 32'd0);
    rst = 1'b0;

    // Empty FIFO after reset: mid-scale duty, first boundary underflows.
    enable = 1'b1;
    wait_tick(w);
    check("t1_first_tick", 32'(w), 32'd256);
    check("t1_uf_b1", 32'(underflow), 32'd1);
    measure(hi, w);
    check("t1_high_count", 32'(hi), 32'd128);

    // Duty sweep.
    clr_underflow = 1'b1;
    cyc(1);
    clr_underflow = 1'b0;
    check("t2_uf_clr", 32'(underflow), 32'd0);
    push(8'h00);
    push(8'h40);
    push(8'hFF);
    push(8'h01);
    measure(hi, w);
    check("t2_duty00", 32'(hi), 32'd0);
    measure(hi, w);
    check("t2_duty40", 32'(hi), 32'd64);
    check("t2_tick_spacing_a", 32'(w), 32'd0);
    measure(hi, w);
    check("t2_dutyFF", 32'(hi), 32'd255);
    check("t2_tick_spacing_b", 32'(w), 32'd0);
    measure(hi, w);
    check("t2_duty01", 32'(hi), 32'd1);
    check("t2_tick_spacing_c", 32'(w), 32'd0);

    // Backpressure while disabled.
    enable = 1'b0;
    cyc(1);
    check("t3_pwm_off", 32'(pwm_out), 32'd0);
    for (int i = 0; i < 5; i++) d[i] = 8'($urandom_range(2, 253));
    for (int i = 0; i < 4; i++) push(d[i]);
    check("t3_ready_full", 32'(s_if.ready), 32'd0);
    check("t3_level_full", 32'(fifo_level), 32'd4);
    s_if.valid = 1'b1;
    s_if.data = d[4];
    cyc(3);
    check("t3_level_held", 32'(fifo_level), 32'd4);
    enable = 1'b1;
    push(d[4]);
    for (int i = 1; i < 5; i++) begin
      measure(hi, w);
      check("t3_order", 32'(hi), 32'(d[i]));
    end

    // Underflow: duty repeats, sticky flag, clear and set/clear race.
    check("t4_uf_set", 32'(underflow), 32'd1);
    measure(hi, w);
    check("t4_duty_repeat", 32'(hi), 32'(d[4]));
    clr_underflow = 1'b1;
    cyc(1);
    clr_underflow = 1'b0;
    check("t4_uf_clr", 32'(underflow), 32'd0);
    cyc(254);
    clr_underflow = 1'b1;
    cyc(1);
    clr_underflow = 1'b0;
    check("t4_race_tick", 32'(sample_tick), 32'd1);
    check("t4_race_uf", 32'(underflow), 32'd1);

    // Push on the boundary cycle into an empty FIFO.
    clr_underflow = 1'b1;
    cyc(1);
    clr_underflow = 1'b0;
    check("t5_uf_clr", 32'(underflow), 32'd0);
    cyc(254);
    x = 8'($urandom_range(2, 253));
    s_if.valid = 1'b1;
    s_if.data = x;
    cyc(1);
    s_if.valid = 1'b0;
    check("t5_uf_on_race", 32'(underflow), 32'd1);
    check("t5_level_race", 32'(fifo_level), 32'd1);
    measure(hi, w);
    check("t5_old_duty", 32'(hi), 32'(d[4]));
    measure(hi, w);
    check("t5_new_duty", 32'(hi), 32'(x));

    // Push and pop on the same edge at level 2.
    a = 8'($urandom_range(0, 255));
    b = 8'($urandom_range(0, 255));
    c = 8'($urandom_range(0, 255));
    push(a);
    push(b);
    cyc(253);
    s_if.valid = 1'b1;
    s_if.data = c;
    cyc(1);
    s_if.valid = 1'b0;
    check("t5_level_pushpop", 32'(fifo_level), 32'd2);
    check("t5_tick_pushpop", 32'(sample_tick), 32'd1);
    measure(hi, w);
    check("t5_a", 32'(hi), 32'(a));
    measure(hi, w);
    check("t5_b", 32'(hi), 32'(b));
    measure(hi, w);
    check("t5_c", 32'(hi), 32'(c));

    // Enable toggle mid-period.
    cyc(100);
    enable = 1'b0;
    cyc(1);
    check("t6_pwm_off", 32'(pwm_out), 32'd0);
    push(8'hF0);
    cyc(5);
    check("t6_no_pop", 32'(fifo_level), 32'd1);
    enable = 1'b1;
    wait_tick(w);
    check("t6_full_period", 32'(w), 32'd256);
    measure(hi, w);
    check("t6_new_duty", 32'(hi), 32'd240);

    // Asynchronous reset in the middle of a high phase with samples buffered.
    push(8'd11);
    push(8'd22);
    cyc(40);
    check("rst2_pwm_before", 32'(pwm_out), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("rst2_pwm", 32'(pwm_out), 32'd0);
    check("rst2_ready", 32'(s_if.ready), 32'd1);
    check("rst2_level", 32'(fifo_level), 32'd0);
    check("rst2_uf", 32'(underflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic against the model.
    rate = 1;
    for (int i = 0; i < 4000; i++) begin
      if (i % 1000 == 0) rate = (i / 1000 == 1) ? 50 : ((i / 1000 == 2) ? 5 : 1);
      s_if.valid = ($urandom_range(0, 99) < rate);
      s_if.data = 8'($urandom_range(0, 255));
      clr_underflow = ($urandom_range(0, 99) == 0);
      if (enable && $urandom_range(0, 999) == 0) enable = 1'b0;
      else if (!enable && $urandom_range(0, 49) == 0) enable = 1'b1;
      @(negedge clk);
    end
    s_if.valid = 1'b0;
    clr_underflow = 1'b0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
